// File: rtl/mem2wb_pipe.sv
// MEM->WB pipeline register: LANES write-back records per bundle, valid/ready
// handshake with a two-entry skid buffer and same-cycle WAW lane qualification.
module mem2wb_pipe #(
  parameter int LANES      = 2,
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        mem_valid_i,
  output logic                        mem_ready_o,
  input  logic [LANES*REG_ADDR_W-1:0] mem_wd_i,
  input  logic [LANES-1:0]            mem_wreg_i,
  input  logic [LANES*DATA_W-1:0]     mem_wdata_i,
  output logic                        wb_valid_o,
  input  logic                        wb_ready_i,
  output logic [LANES*REG_ADDR_W-1:0] wb_wd_o,
  output logic [LANES-1:0]            wb_wreg_o,
  output logic [LANES*DATA_W-1:0]     wb_wdata_o
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t                        state_q, state_d;
  logic                          ready_q;
  logic [LANES*REG_ADDR_W-1:0]   main_wd, skid_wd;
  logic [LANES-1:0]              main_wreg, skid_wreg;
  logic [LANES*DATA_W-1:0]       main_wdata, skid_wdata;
  logic [LANES-1:0]              qual_wreg;
  logic                          accept, drain;
  logic                          load_main_in, load_main_skid, load_skid;

  // Drop writes to register 0; on address collision only the youngest lane keeps its write.
  always_comb begin
    qual_wreg = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      qual_wreg[i] = mem_wreg_i[i] && (mem_wd_i[i*REG_ADDR_W +: REG_ADDR_W] != '0);
      for (int unsigned j = i + 1; j < LANES; j++) begin
        if (mem_wreg_i[j] &&
            (mem_wd_i[j*REG_ADDR_W +: REG_ADDR_W] == mem_wd_i[i*REG_ADDR_W +: REG_ADDR_W]))
          qual_wreg[i] = 1'b0;
      end
    end
  end

  assign wb_valid_o  = (state_q != S_EMPTY);
  assign mem_ready_o = ready_q;
  assign accept      = mem_valid_i && ready_q;
  assign drain       = wb_valid_o && wb_ready_i;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      S_EMPTY: if (accept) begin
        load_main_in = 1'b1;
        state_d      = S_ONE;
      end
      S_ONE: begin
        if (accept && drain) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = S_FULL;
        end else if (drain) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: if (drain) begin
        load_main_skid = 1'b1;
        state_d        = S_ONE;
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush_i) begin
      state_d        = S_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // ready is registered from the next state so wb_ready_i never reaches mem_ready_o combinationally.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= S_EMPTY;
      ready_q    <= 1'b1;
      main_wd    <= '0;
      main_wreg  <= '0;
      main_wdata <= '0;
      skid_wd    <= '0;
      skid_wreg  <= '0;
      skid_wdata <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != S_FULL);
      if (load_main_in) begin
        main_wd    <= mem_wd_i;
        main_wreg  <= qual_wreg;
        main_wdata <= mem_wdata_i;
      end else if (load_main_skid) begin
        main_wd    <= skid_wd;
        main_wreg  <= skid_wreg;
        main_wdata <= skid_wdata;
      end
      if (load_skid) begin
        skid_wd    <= mem_wd_i;
        skid_wreg  <= qual_wreg;
        skid_wdata <= mem_wdata_i;
      end
    end
  end

  assign wb_wd_o    = main_wd;
  assign wb_wdata_o = main_wdata;
  assign wb_wreg_o  = main_wreg & {LANES{wb_valid_o}};

endmodule

// File: tb/tb_mem2wb_pipe.sv
// Directed and scoreboard bench for mem2wb_pipe (2-lane/64b main DUT, plus 4-lane/32b and 1-lane/32b).
module tb_mem2wb_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // main DUT: LANES=2, DATA_W=64
  logic         flush, mem_valid, mem_ready, wb_valid, wb_ready;
  logic [9:0]   mem_wd, wb_wd;
  logic [1:0]   mem_wreg, wb_wreg;
  logic [127:0] mem_wdata, wb_wdata;
  logic [140:0] got_m;
  assign got_m = {wb_valid, wb_wd, wb_wreg, wb_wdata};

  // LANES=4, DATA_W=32
  logic         f4, v4, r4o, wv4, wr4;
  logic [19:0]  wd4, wbwd4;
  logic [3:0]   we4, wbwe4;
  logic [127:0] d4, wbd4;

  // LANES=1, DATA_W=32
  logic         f1, v1, r1o, wv1, wr1;
  logic [4:0]   wd1, wbwd1;
  logic         we1, wbwe1;
  logic [31:0]  d1, wbd1;

  mem2wb_pipe #(.LANES(2), .REG_ADDR_W(5), .DATA_W(64)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush),
    .mem_valid_i(mem_valid), .mem_ready_o(mem_ready),
    .mem_wd_i(mem_wd), .mem_wreg_i(mem_wreg), .mem_wdata_i(mem_wdata),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
    .wb_wd_o(wb_wd), .wb_wreg_o(wb_wreg), .wb_wdata_o(wb_wdata)
  );

  mem2wb_pipe #(.LANES(4), .REG_ADDR_W(5), .DATA_W(32)) u_dut4 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(f4),
    .mem_valid_i(v4), .mem_ready_o(r4o),
    .mem_wd_i(wd4), .mem_wreg_i(we4), .mem_wdata_i(d4),
    .wb_valid_o(wv4), .wb_ready_i(wr4),
    .wb_wd_o(wbwd4), .wb_wreg_o(wbwe4), .wb_wdata_o(wbd4)
  );

  mem2wb_pipe #(.LANES(1), .REG_ADDR_W(5), .DATA_W(32)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(f1),
    .mem_valid_i(v1), .mem_ready_o(r1o),
    .mem_wd_i(wd1), .mem_wreg_i(we1), .mem_wdata_i(d1),
    .wb_valid_o(wv1), .wb_ready_i(wr1),
    .wb_wd_o(wbwd1), .wb_wreg_o(wbwe1), .wb_wdata_o(wbd1)
  );

  typedef struct {
    logic [9:0]   wd;
    logic [1:0]   wreg;
    logic [127:0] data;
  } bundle_t;
  bundle_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [1:0] we, input logic [63:0] x0, input logic [63:0] x1);
    mem_valid = v;
    mem_wd    = {a1, a0};
    mem_wreg  = we;
    mem_wdata = {x1, x0};
  endtask

  function automatic logic [140:0] mk(input logic v, input logic [4:0] a0, input logic [4:0] a1,
                                      input logic [1:0] we, input logic [63:0] x0, input logic [63:0] x1);
    return {v, a1, a0, we, x1, x0};
  endfunction

  // Reference lane mask: walk youngest to oldest, a lane writes only if no younger lane claimed its register.
  function automatic logic [1:0] ref_mask(input logic [9:0] wd, input logic [1:0] we);
    logic [31:0] claimed;
    logic [1:0]  r;
    logic [4:0]  a;
    claimed = '0;
    r = '0;
    for (int i = 1; i >= 0; i--) begin
      a = wd[i*5 +: 5];
      if (we[i]) begin
        if (a != 5'd0 && !claimed[a]) r[i] = 1'b1;
        claimed[a] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      flush = $urandom_range(0, 1); mem_valid = 1'b1; wb_ready = $urandom_range(0, 1);
      mem_wd = 10'($urandom); mem_wreg = 2'($urandom);
      mem_wdata = {$urandom, $urandom, $urandom, $urandom};
      f4 = 1'b0; v4 = 1'b1; wr4 = 1'b0; wd4 = 20'($urandom); we4 = 4'hF; d4 = {4{$urandom}};
      f1 = 1'b0; v1 = 1'b1; wr1 = 1'b0; wd1 = 5'd3; we1 = 1'b1; d1 = $urandom;
      tick();
    end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", wb_valid); end
    checks++; if (wb_wreg !== 2'b00) begin errors++; $display("FAIL reset_wreg: got %b expected 00", wb_wreg); end
    checks++; if (wb_wd !== 10'd0) begin errors++; $display("FAIL reset_wd: got %h expected 0", wb_wd); end
    checks++; if (wb_wdata !== 128'd0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", wb_wdata); end
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", mem_ready); end
    checks++; if ({wv4, wbwe4, wv1, wbwe1, r4o, r1o} !== 8'b00000011) begin
      errors++; $display("FAIL reset_other: got %b expected 00000011", {wv4, wbwe4, wv1, wbwe1, r4o, r1o});
    end
    flush = 1'b0; wb_ready = 1'b1; drive(1'b0, 5'd0, 5'd0, 2'b00, 64'd0, 64'd0);
    v4 = 1'b0; v1 = 1'b0; wr4 = 1'b1; wr1 = 1'b1;
    rst_n = 1'b1;
    tick();
    checks++; if ({wb_valid, mem_ready} !== 2'b01) begin
      errors++; $display("FAIL post_reset: valid/ready got %b expected 01", {wb_valid, mem_ready});
    end
  endtask

  task automatic test_streaming();
    logic [140:0] exp;
    wb_ready = 1'b1;
    drive(1'b1, 5'd3, 5'd4, 2'b11, 64'h11, 64'h22);
    for (int k = 0; k < 3; k++) begin
      tick();
      exp = mk(1'b1, 5'd3, 5'd4, 2'b11, 64'h11 + k, 64'h22 + k);
      checks++; if (got_m !== exp) begin errors++; $display("FAIL stream%0d: got %h expected %h", k, got_m, exp); end
      checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d: got %b expected 1", k, mem_ready); end
      if (k < 2) drive(1'b1, 5'd3, 5'd4, 2'b11, 64'h11 + k + 1, 64'h22 + k + 1);
      else mem_valid = 1'b0;
    end
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL stream_end: valid got %b expected 0", wb_valid); end
  endtask

  task automatic test_backpressure();
    logic [140:0] ea, eb, ec;
    ea = mk(1'b1, 5'd1, 5'd2, 2'b11, 64'hA0, 64'hA1);
    eb = mk(1'b1, 5'd8, 5'd9, 2'b11, 64'hB0, 64'hB1);
    ec = mk(1'b1, 5'd10, 5'd11, 2'b11, 64'hC0, 64'hC1);
    wb_ready = 1'b0;
    drive(1'b1, 5'd1, 5'd2, 2'b11, 64'hA0, 64'hA1);
    tick();
    checks++; if ({got_m, mem_ready} !== {ea, 1'b1}) begin errors++; $display("FAIL bp_a: got %h expected %h", {got_m, mem_ready}, {ea, 1'b1}); end
    drive(1'b1, 5'd8, 5'd9, 2'b11, 64'hB0, 64'hB1);
    tick();
    checks++; if ({got_m, mem_ready} !== {ea, 1'b0}) begin errors++; $display("FAIL bp_full: got %h expected %h", {got_m, mem_ready}, {ea, 1'b0}); end
    drive(1'b1, 5'd10, 5'd11, 2'b11, 64'hC0, 64'hC1);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if ({got_m, mem_ready} !== {ea, 1'b0}) begin errors++; $display("FAIL bp_hold%0d: got %h expected %h", c, {got_m, mem_ready}, {ea, 1'b0}); end
    end
    wb_ready = 1'b1;
    tick();
    checks++; if ({got_m, mem_ready} !== {eb, 1'b1}) begin errors++; $display("FAIL bp_b: got %h expected %h", {got_m, mem_ready}, {eb, 1'b1}); end
    tick();
    checks++; if (got_m !== ec) begin errors++; $display("FAIL bp_c: got %h expected %h", got_m, ec); end
    mem_valid = 1'b0;
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL bp_end: valid got %b expected 0", wb_valid); end
  endtask

  task automatic test_collision();
    logic [140:0] exp;
    wb_ready = 1'b1;
    drive(1'b1, 5'd7, 5'd7, 2'b11, 64'h1234, 64'h5678);
    tick();
    exp = mk(1'b1, 5'd7, 5'd7, 2'b10, 64'h1234, 64'h5678);
    checks++; if (got_m !== exp) begin errors++; $display("FAIL waw: got %h expected %h", got_m, exp); end
    drive(1'b1, 5'd6, 5'd6, 2'b00, 64'h1, 64'h2);
    tick();
    exp = mk(1'b1, 5'd6, 5'd6, 2'b00, 64'h1, 64'h2);
    checks++; if (got_m !== exp) begin errors++; $display("FAIL nowrite: got %h expected %h", got_m, exp); end
    drive(1'b1, 5'd0, 5'd5, 2'b11, 64'hDEAD, 64'hBEEF);
    tick();
    exp = mk(1'b1, 5'd0, 5'd5, 2'b10, 64'hDEAD, 64'hBEEF);
    checks++; if (got_m !== exp) begin errors++; $display("FAIL zero_reg: got %h expected %h", got_m, exp); end
    drive(1'b1, 5'd9, 5'd9, 2'b01, 64'h9, 64'h99);
    tick();
    exp = mk(1'b1, 5'd9, 5'd9, 2'b01, 64'h9, 64'h99);
    checks++; if (got_m !== exp) begin errors++; $display("FAIL same_addr_idle: got %h expected %h", got_m, exp); end
    mem_valid = 1'b0;
    tick();
    checks++; if ({wb_valid, wb_wreg} !== 3'b000) begin errors++; $display("FAIL wreg_mask: got %b expected 000", {wb_valid, wb_wreg}); end

    // four lanes: lane0 wd3 loses to lane2, lane3 targets r0
    v4 = 1'b1; wd4 = {5'd0, 5'd3, 5'd5, 5'd3}; we4 = 4'hF; d4 = 128'h44443333_22221111_00001111_AAAA5555;
    tick();
    checks++; if ({wv4, wbwe4, wbwd4, wbd4} !== {1'b1, 4'b0110, 20'({5'd0, 5'd3, 5'd5, 5'd3}), 128'h44443333_22221111_00001111_AAAA5555}) begin
      errors++; $display("FAIL lanes4_a: got %b %b %h expected 1 0110", wv4, wbwe4, wbd4);
    end
    wd4 = {4{5'd9}}; we4 = 4'b0111;
    tick();
    checks++; if ({wv4, wbwe4} !== 5'b10100) begin errors++; $display("FAIL lanes4_b: got %b expected 10100", {wv4, wbwe4}); end
    v4 = 1'b0;
    tick();
    checks++; if ({wv4, wbwe4} !== 5'b00000) begin errors++; $display("FAIL lanes4_idle: got %b expected 00000", {wv4, wbwe4}); end

    v1 = 1'b1; wd1 = 5'd0; we1 = 1'b1; d1 = 32'hCAFE0000;
    tick();
    checks++; if ({wv1, wbwe1, wbd1} !== {2'b10, 32'hCAFE0000}) begin errors++; $display("FAIL lane1_r0: got %b%b expected 10", wv1, wbwe1); end
    wd1 = 5'd6; d1 = 32'h0000F00D;
    tick();
    checks++; if ({wv1, wbwe1, wbwd1, wbd1} !== {2'b11, 5'd6, 32'h0000F00D}) begin errors++; $display("FAIL lane1_w: got %b%b %h expected 11 f00d", wv1, wbwe1, wbd1); end
    v1 = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    wb_ready = 1'b0;
    drive(1'b1, 5'd1, 5'd2, 2'b11, 64'h1, 64'h2);
    tick();
    drive(1'b1, 5'd3, 5'd4, 2'b11, 64'h3, 64'h4);
    tick();
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_full: ready got %b expected 0", mem_ready); end
    flush = 1'b1;
    drive(1'b1, 5'd13, 5'd14, 2'b11, 64'hD0, 64'hD1);
    tick();
    checks++; if ({wb_valid, wb_wreg, mem_ready} !== 4'b0001) begin
      errors++; $display("FAIL flush_full: valid/wreg/ready got %b expected 0001", {wb_valid, wb_wreg, mem_ready});
    end
    flush = 1'b0; mem_valid = 1'b0; wb_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost%0d: valid got %b expected 0", c, wb_valid); end
    end
    wb_ready = 1'b0;
    drive(1'b1, 5'd1, 5'd2, 2'b11, 64'h1, 64'h2);
    tick();
    flush = 1'b1;
    drive(1'b1, 5'd15, 5'd16, 2'b11, 64'hE0, 64'hE1);
    tick();
    checks++; if ({wb_valid, mem_ready} !== 2'b01) begin errors++; $display("FAIL flush_one: got %b expected 01", {wb_valid, mem_ready}); end
    flush = 1'b0; mem_valid = 1'b0; wb_ready = 1'b1;
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_one_after: valid got %b expected 0", wb_valid); end
  endtask

  task automatic test_random();
    bundle_t b;
    logic [140:0] exp;
    sb.delete();
    for (int c = 0; c < 400; c++) begin
      checks++; if ({wb_valid, mem_ready} !== {sb.size() != 0, sb.size() < 2}) begin
        errors++; $display("FAIL rnd_state%0d: valid/ready got %b%b queued %0d", c, wb_valid, mem_ready, sb.size());
      end
      if (wb_valid && sb.size() != 0) begin
        exp = {1'b1, sb[0].wd, sb[0].wreg, sb[0].data};
        checks++; if (got_m !== exp) begin errors++; $display("FAIL rnd_data%0d: got %h expected %h", c, got_m, exp); end
      end
      mem_valid = ($urandom_range(0, 3) != 0);
      mem_wd    = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      mem_wreg  = 2'($urandom);
      mem_wdata = {$urandom, $urandom, $urandom, $urandom};
      wb_ready  = (c % 50 < 25) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      if (wb_valid && wb_ready && sb.size() != 0) void'(sb.pop_front());
      if (mem_valid && mem_ready) begin
        b.wd = mem_wd; b.wreg = ref_mask(mem_wd, mem_wreg); b.data = mem_wdata;
        sb.push_back(b);
      end
      tick();
    end
    mem_valid = 1'b0; wb_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (wb_valid && sb.size() != 0) begin
        exp = {1'b1, sb[0].wd, sb[0].wreg, sb[0].data};
        checks++; if (got_m !== exp) begin errors++; $display("FAIL rnd_drain%0d: got %h expected %h", c, got_m, exp); end
        void'(sb.pop_front());
      end
      tick();
    end
    checks++; if ({wb_valid, 32'(sb.size())} !== 33'd0) begin
      errors++; $display("FAIL rnd_final: valid %b leftover %0d expected 0 0", wb_valid, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_collision();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
